pc_halt_monitor: RTL

//  Synthesizable run-control monitor for the single-cycle RV32 core: samples the core PC every

---
 rtl/pc_halt_monitor_if.sv | 29 ++
 rtl/pc_halt_monitor.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pc_halt_monitor_if.sv
// Run-control bundle between the core harness and pc_halt_monitor.
// master drives run/pc/history index; slave returns status, counters and history data.
interface pc_halt_monitor_if #(
    parameter int CNT_W      = 32,
    parameter int HIST_DEPTH = 8
);
    localparam int IDX_W = $clog2(HIST_DEPTH);

    logic             run_i;
    logic [31:0]      pc_i;
    logic             halt_o;
    logic             done_o;
    logic             hang_o;
    logic             timeout_o;
    logic [CNT_W-1:0] cycle_cnt_o;
    logic [31:0]      last_pc_o;
    logic [IDX_W-1:0] hist_idx_i;
    logic [31:0]      hist_pc_o;

    modport master (
        output run_i, pc_i, hist_idx_i,
        input  halt_o, done_o, hang_o, timeout_o, cycle_cnt_o, last_pc_o, hist_pc_o
    );

    modport slave (
        input  run_i, pc_i, hist_idx_i,
        output halt_o, done_o, hang_o, timeout_o, cycle_cnt_o, last_pc_o, hist_pc_o
    );
endinterface

// File: rtl/pc_halt_monitor.sv
// Run-control monitor: counts RUN cycles, flags END_PC reached, frozen PC or cycle timeout.
// Flags registered (visible the cycle after the exit edge); no backpressure. PC_HIST_EN adds a PC history buffer.
module pc_halt_monitor #(
    parameter logic [31:0] END_PC      = 32'h00000CCC,
    parameter int          MAX_CYCLES  = 100000,
    parameter int          STUCK_LIMIT = 16,
    parameter int          CNT_W       = 32,
    parameter int          HIST_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rstn,
    pc_halt_monitor_if.slave mon
);
    localparam int SAME_W = $clog2(STUCK_LIMIT + 1);
    localparam int IDX_W  = $clog2(HIST_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_DONE = 3'd2,
        S_HANG = 3'd3,
        S_TOUT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic [31:0]       last_pc_q;
    logic              last_pc_vld_q;
    logic [SAME_W-1:0] same_cnt_q;
    logic [SAME_W-1:0] same_inc;
    logic              run_edge;

    // Updated values of this edge; exit conditions look at these, not the old registers.
    assign cnt_inc  = (cycle_cnt_q == {CNT_W{1'b1}}) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
    assign same_inc = (last_pc_vld_q && (mon.pc_i == last_pc_q)) ? same_cnt_q + 1'b1
                                                                 : {SAME_W{1'b0}};
    assign run_edge = (state_q == S_RUN) && mon.run_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!mon.run_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_RUN;
                S_RUN: begin
                    // END_PC outranks hang: programs finish on a self-loop at END_PC.
                    if (mon.pc_i == END_PC)
                        state_d = S_DONE;
                    else if (same_inc == SAME_W'(STUCK_LIMIT))
                        state_d = S_HANG;
                    else if (cnt_inc == CNT_W'(MAX_CYCLES))
                        state_d = S_TOUT;
                    else
                        state_d = S_RUN;
                end
                S_DONE, S_HANG, S_TOUT: state_d = state_q;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_cnt_q   <= '0;
            last_pc_q     <= '0;
            last_pc_vld_q <= 1'b0;
            same_cnt_q    <= '0;
        end else if ((state_q == S_IDLE) && mon.run_i) begin
            cycle_cnt_q   <= '0;
            last_pc_vld_q <= 1'b0;
            same_cnt_q    <= '0;
        end else if (run_edge) begin
            cycle_cnt_q   <= cnt_inc;
            last_pc_q     <= mon.pc_i;
            last_pc_vld_q <= 1'b1;
            same_cnt_q    <= same_inc;
        end
    end

    assign mon.done_o      = (state_q == S_DONE);
    assign mon.hang_o      = (state_q == S_HANG);
    assign mon.timeout_o   = (state_q == S_TOUT);
    assign mon.halt_o      = mon.done_o | mon.hang_o | mon.timeout_o;
    assign mon.cycle_cnt_o = cycle_cnt_q;
    assign mon.last_pc_o   = last_pc_q;

`ifdef PC_HIST_EN
    logic [31:0]      hist_mem [HIST_DEPTH];
    logic [IDX_W-1:0] wr_ptr_q;
    logic [IDX_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
        end else if (run_edge) begin
            hist_mem[wr_ptr_q] <= mon.pc_i;
            wr_ptr_q           <= wr_ptr_q + 1'b1;
        end
    end

    // Index 0 is the newest entry, i.e. the slot just behind the write pointer.
    assign rd_ptr        = wr_ptr_q - IDX_W'(1) - mon.hist_idx_i;
    assign mon.hist_pc_o = hist_mem[rd_ptr];
`else
    logic [IDX_W-1:0] unused_hist_idx;
    assign unused_hist_idx = mon.hist_idx_i;
    assign mon.hist_pc_o   = 32'h0;
`endif
endmodule
